// File: rtl/updi_pkg.sv
// updi_pkg: shared types for the UPDI transaction sequencer.
// Error codes reported per command and the controller states.
package updi_pkg;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_FRAME   = 2'd1,
        ERR_ECHO    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } updi_err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ECHO,
        S_RECV,
        S_DONE,
        S_ERR
    } updi_state_t;

endpackage

// File: rtl/updi_txn_ctrl_if.sv
// updi_txn_ctrl_if: command, byte-stream and UART-side signals.
// slave is the controller view, master the host/UART view.
interface updi_txn_ctrl_if
    import updi_pkg::*;
#(
    parameter int LEN_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_tx_len;
    logic [LEN_W-1:0] cmd_rx_len;
    logic [7:0]       tx_byte;
    logic             tx_byte_valid;
    logic             tx_byte_ready;
    logic [7:0]       rx_byte;
    logic             rx_byte_valid;
    logic             done;
    updi_err_t        err_code;
    logic             busy;
    logic [7:0]       uart_tx_data;
    logic             uart_transmit_start;
    logic             uart_transmit_ready;
    logic [7:0]       uart_rx_data;
    logic             uart_rx_data_valid;
    logic             uart_rx_error;

    modport slave (
        input  cmd_valid, cmd_tx_len, cmd_rx_len,
        input  tx_byte, tx_byte_valid,
        input  uart_transmit_ready,
        input  uart_rx_data, uart_rx_data_valid,
        input  uart_rx_error,
        output cmd_ready, tx_byte_ready,
        output rx_byte, rx_byte_valid,
        output done, err_code, busy,
        output uart_tx_data, uart_transmit_start
    );

    modport master (
        output cmd_valid, cmd_tx_len, cmd_rx_len,
        output tx_byte, tx_byte_valid,
        output uart_transmit_ready,
        output uart_rx_data, uart_rx_data_valid,
        output uart_rx_error,
        input  cmd_ready, tx_byte_ready,
        input  rx_byte, rx_byte_valid,
        input  done, err_code, busy,
        input  uart_tx_data, uart_transmit_start
    );

endinterface

// File: rtl/updi_timeout.sv
// updi_timeout: loadable down-counter guarding echo/response waits.
// The clearing cycle counts as the first cycle of the wait.
module updi_timeout #(
    parameter int CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] r_cnt;

    // Reload on clear, otherwise count down to zero and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= LOAD_VAL;
        end else if (i_enable && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/updi_txn_ctrl.sv
// updi_txn_ctrl: sends N bytes over the looped-back UPDI UART,
// checks each echo, then collects M response bytes under a timeout.
module updi_txn_ctrl
    import updi_pkg::*;
#(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          clk,
    input  logic          rst,
    updi_txn_ctrl_if.slave bus
);

    updi_state_t      r_state;
    logic [LEN_W-1:0] r_tx_cnt;
    logic [LEN_W-1:0] r_rx_cnt;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_rx_byte;
    logic             r_rx_valid;
    logic             r_done;
    updi_err_t        r_err;

    logic w_wait;
    logic w_tmo_clr;
    logic w_expired;

    // Counter is held loaded outside the waits and on every byte.
    assign w_wait    = (r_state == S_ECHO) || (r_state == S_RECV);
    assign w_tmo_clr = !w_wait || bus.uart_rx_data_valid;

    updi_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_tmo_clr),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    // Sequencer: done and err_code are set on the entering edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_tx_data  <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= ERR_NONE;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_tx_cnt <= bus.cmd_tx_len;
                        r_rx_cnt <= bus.cmd_rx_len;
                        r_err    <= ERR_NONE;
                        if (bus.cmd_tx_len != '0) begin
                            r_state <= S_LOAD;
                        end else if (bus.cmd_rx_len != '0) begin
                            r_state <= S_RECV;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.tx_byte_valid) begin
                        r_tx_data <= bus.tx_byte;
                        r_tx_cnt  <= r_tx_cnt - LEN_W'(1);
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.uart_transmit_ready) begin
                        r_state <= S_ECHO;
                    end
                end
                S_ECHO: begin
                    if (bus.uart_rx_error) begin
                        r_err   <= ERR_FRAME;
                        r_done  <= 1'b1;
                        r_state <= S_ERR;
                    end else if (bus.uart_rx_data_valid) begin
                        if (bus.uart_rx_data != r_tx_data) begin
                            r_err   <= ERR_ECHO;
                            r_done  <= 1'b1;
                            r_state <= S_ERR;
                        end else if (r_tx_cnt != '0) begin
                            r_state <= S_LOAD;
                        end else if (r_rx_cnt != '0) begin
                            r_state <= S_RECV;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (w_expired) begin
                        r_err   <= ERR_TIMEOUT;
                        r_done  <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_RECV: begin
                    if (bus.uart_rx_error) begin
                        r_err   <= ERR_FRAME;
                        r_done  <= 1'b1;
                        r_state <= S_ERR;
                    end else if (bus.uart_rx_data_valid) begin
                        r_rx_byte  <= bus.uart_rx_data;
                        r_rx_valid <= 1'b1;
                        r_rx_cnt   <= r_rx_cnt - LEN_W'(1);
                        if (r_rx_cnt == LEN_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (w_expired) begin
                        r_err   <= ERR_TIMEOUT;
                        r_done  <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Start is gated by ready so it can never fire while busy.
    assign bus.uart_transmit_start =
        (r_state == S_SEND) && bus.uart_transmit_ready;

    assign bus.cmd_ready     = (r_state == S_IDLE);
    assign bus.tx_byte_ready = (r_state == S_LOAD);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.uart_tx_data  = r_tx_data;
    assign bus.rx_byte       = r_rx_byte;
    assign bus.rx_byte_valid = r_rx_valid;
    assign bus.done          = r_done;
    assign bus.err_code      = r_err;

endmodule

// File: tb/tb_updi_txn_ctrl.sv
// tb_updi_txn_ctrl: directed scenarios against a cycle-level
// looped-back UART model with echo forcing and a target responder.
module tb_updi_txn_ctrl;
    import updi_pkg::*;

    localparam int TMO      = 2000;
    localparam int TX_CYC   = 40;
    localparam int STOP_CYC = 8;

    logic clk;
    logic rst;

    updi_txn_ctrl_if #(.LEN_W(4)) bus ();

    updi_txn_ctrl #(
        .LEN_W          (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int         n_start  = 0;
    int         n_viol   = 0;
    int         n_done   = 0;
    int         n_rxv    = 0;
    int         done_cyc = 0;
    int         rx_cyc   = 0;
    logic [7:0] rx_last  = 8'h00;

    bit         force_en   = 0;
    logic [7:0] force_val  = 8'h00;
    bit         inj_err    = 0;
    bit         resp_en    = 0;
    int         resp_after = 0;
    int         resp_dly   = 0;
    logic [7:0] resp_val   = 8'h00;
    int         echo_cnt   = 0;
    int         echo_cyc   = 0;
    int         resp_cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: cycle %0d, limit 60000", cyc);
        $fatal(1);
    end

    // UART model: tx looped to rx, echo after 32 cycles,
    // ready low for 8 more cycles of stop bits.
    initial begin
        bit         s;
        bit         r;
        logic [7:0] d;
        int         m_busy;
        int         resp_cnt;
        logic [7:0] m_data;
        m_busy   = 0;
        resp_cnt = 0;
        m_data   = 8'h00;
        bus.uart_transmit_ready = 1'b1;
        bus.uart_rx_data_valid  = 1'b0;
        bus.uart_rx_error       = 1'b0;
        bus.uart_rx_data        = 8'h00;
        forever begin
            @(negedge clk);
            s = bus.uart_transmit_start;
            d = bus.uart_tx_data;
            r = rst;
            @(posedge clk);
            #1;
            bus.uart_rx_data_valid = 1'b0;
            bus.uart_rx_error      = 1'b0;
            if (r) begin
                m_busy   = 0;
                resp_cnt = 0;
                bus.uart_transmit_ready = 1'b1;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        bus.uart_rx_data_valid = 1'b1;
                        bus.uart_rx_data       = resp_val;
                        resp_cyc = cyc;
                    end
                end
                if (s) begin
                    m_data = d;
                    m_busy = TX_CYC;
                    bus.uart_transmit_ready = 1'b0;
                end else if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == STOP_CYC) begin
                        bus.uart_rx_data_valid = 1'b1;
                        bus.uart_rx_data =
                            force_en ? force_val : m_data;
                        bus.uart_rx_error = inj_err;
                        echo_cnt++;
                        echo_cyc = cyc;
                        if (resp_en && echo_cnt == resp_after) begin
                            resp_cnt = resp_dly;
                            resp_en  = 0;
                        end
                    end
                    if (m_busy == 0) begin
                        bus.uart_transmit_ready = 1'b1;
                    end
                end
            end
        end
    end

    // Event monitor sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (bus.uart_transmit_start) begin
            n_start++;
            if (!bus.uart_transmit_ready) n_viol++;
        end
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (bus.rx_byte_valid) begin
            n_rxv++;
            rx_last = bus.rx_byte;
            rx_cyc  = cyc;
        end
    end

    task automatic send_cmd(input logic [3:0] tl,
                            input logic [3:0] rl);
        @(negedge clk);
        bus.cmd_tx_len = tl;
        bus.cmd_rx_len = rl;
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b);
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = bus.tx_byte_ready;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL feed_wait: byte %h, ready 0 want 1", b);
        end else begin
            bus.tx_byte       = b;
            bus.tx_byte_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.tx_byte_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            ok = bus.done;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_cmd_ready: got %b want 1",
                     bus.cmd_ready);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b want 0", bus.busy);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_done: got %b want 0", bus.done);
        end
        n_cmp++;
        if (bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_err: got %0d want 0", bus.err_code);
        end
        n_cmp++;
        if (bus.tx_byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_tx_rdy: got %b want 0",
                     bus.tx_byte_ready);
        end
        n_cmp++;
        if (bus.rx_byte_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_rx_vld: got %b want 0",
                     bus.rx_byte_valid);
        end
        n_cmp++;
        if (bus.uart_transmit_start !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_start: got %b want 0",
                     bus.uart_transmit_start);
        end
        n_cmp++;
        if (bus.uart_tx_data !== 8'h00 || bus.rx_byte !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_data: got %h/%h want 00/00",
                     bus.uart_tx_data, bus.rx_byte);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_two_bytes;
        int s0, d0, r0;
        bit ok;
        s0 = n_start;
        d0 = n_done;
        r0 = n_rxv;
        send_cmd(4'd2, 4'd0);
        @(negedge clk);
        n_cmp++;
        if (bus.tx_byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL two_rdy_lat: got %b want 1",
                     bus.tx_byte_ready);
        end
        feed_byte(8'h55);
        @(negedge clk);
        n_cmp++;
        if (bus.uart_transmit_start !== 1'b1 ||
            bus.uart_tx_data !== 8'h55) begin
            n_bad++;
            $display("FAIL two_start_lat: got %b/%h want 1/55",
                     bus.uart_transmit_start, bus.uart_tx_data);
        end
        feed_byte(8'hC2);
        wait_done(400, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL two_done_seen: got 0 want 1");
        end
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL two_done_state: busy/err %b/%0d want 1/0",
                     bus.busy, bus.err_code);
        end
        n_cmp++;
        if (done_cyc - echo_cyc !== 1) begin
            n_bad++;
            $display("FAIL two_done_lat: got %0d want 1",
                     done_cyc - echo_cyc);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL two_after: done/rdy %b/%b want 0/1",
                     bus.done, bus.cmd_ready);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_start - s0 !== 2) begin
            n_bad++;
            $display("FAIL two_starts: got %0d want 2", n_start - s0);
        end
        n_cmp++;
        if (n_done - d0 !== 1 || n_rxv - r0 !== 0) begin
            n_bad++;
            $display("FAIL two_pulses: done/rxv %0d/%0d want 1/0",
                     n_done - d0, n_rxv - r0);
        end
    endtask

    task automatic test_echo_mismatch;
        int s0;
        bit ok;
        s0 = n_start;
        force_en  = 1;
        force_val = 8'h54;
        send_cmd(4'd2, 4'd0);
        feed_byte(8'h55);
        wait_done(400, ok);
        force_en = 0;
        n_cmp++;
        if (!ok || bus.err_code !== 2'd2) begin
            n_bad++;
            $display("FAIL echo_err: seen/err %b/%0d want 1/2",
                     ok, bus.err_code);
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if (n_start - s0 !== 1 || bus.tx_byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL echo_no_more: starts/rdy %0d/%b want 1/0",
                     n_start - s0, bus.tx_byte_ready);
        end
        n_cmp++;
        if (bus.err_code !== 2'd2) begin
            n_bad++;
            $display("FAIL echo_err_held: got %0d want 2",
                     bus.err_code);
        end
    endtask

    task automatic test_zero_len;
        send_cmd(4'd0, 4'd0);
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL zero_done: done/err %b/%0d want 1/0",
                     bus.done, bus.err_code);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_idle: rdy/done %b/%b want 1/0",
                     bus.cmd_ready, bus.done);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        send_cmd(4'd2, 4'd1);
        feed_byte(8'h55);
        feed_byte(8'h80);
        wait_done(TMO + 400, ok);
        n_cmp++;
        if (!ok || bus.err_code !== 2'd3) begin
            n_bad++;
            $display("FAIL tmo_err: seen/err %b/%0d want 1/3",
                     ok, bus.err_code);
        end
        // wait opens the cycle after the echo; done TMO later
        n_cmp++;
        if (done_cyc - echo_cyc !== TMO + 1) begin
            n_bad++;
            $display("FAIL tmo_lat: got %0d want %0d",
                     done_cyc - echo_cyc, TMO + 1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_response;
        int r0;
        bit ok;
        r0 = n_rxv;
        resp_val   = 8'h30;
        resp_dly   = 50;
        resp_after = echo_cnt + 2;
        resp_en    = 1;
        send_cmd(4'd2, 4'd1);
        feed_byte(8'h55);
        feed_byte(8'h80);
        wait_done(500, ok);
        n_cmp++;
        if (!ok || bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL resp_err: seen/err %b/%0d want 1/0",
                     ok, bus.err_code);
        end
        n_cmp++;
        if (n_rxv - r0 !== 1 || rx_last !== 8'h30) begin
            n_bad++;
            $display("FAIL resp_byte: n/byte %0d/%h want 1/30",
                     n_rxv - r0, rx_last);
        end
        n_cmp++;
        if (rx_cyc - resp_cyc !== 1 || done_cyc - resp_cyc !== 1) begin
            n_bad++;
            $display("FAIL resp_lat: rx/done %0d/%0d want 1/1",
                     rx_cyc - resp_cyc, done_cyc - resp_cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_resp_boundary;
        bit ok;
        resp_val   = 8'hA5;
        resp_dly   = TMO;
        resp_after = echo_cnt + 1;
        resp_en    = 1;
        send_cmd(4'd1, 4'd1);
        feed_byte(8'h3C);
        wait_done(TMO + 400, ok);
        n_cmp++;
        if (!ok || bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL bnd_err: seen/err %b/%0d want 1/0",
                     ok, bus.err_code);
        end
        n_cmp++;
        if (rx_last !== 8'hA5 || done_cyc - resp_cyc !== 1) begin
            n_bad++;
            $display("FAIL bnd_byte: byte/lat %h/%0d want a5/1",
                     rx_last, done_cyc - resp_cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_error;
        bit ok;
        inj_err = 1;
        send_cmd(4'd1, 4'd0);
        feed_byte(8'h55);
        wait_done(400, ok);
        inj_err = 0;
        n_cmp++;
        if (!ok || bus.err_code !== 2'd1) begin
            n_bad++;
            $display("FAIL frame_err: seen/err %b/%0d want 1/1",
                     ok, bus.err_code);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_in_recv;
        int  e0, d0;
        bit  seen;
        bit  ok;
        e0 = echo_cnt;
        send_cmd(4'd1, 4'd2);
        feed_byte(8'h55);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (echo_cnt != e0);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (!seen || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_in_recv: echo/busy %b/%b want 1/1",
                     seen, bus.busy);
        end
        d0 = n_done;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_idle: busy/rdy %b/%b want 0/1",
                     bus.busy, bus.cmd_ready);
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (n_done !== d0) begin
            n_bad++;
            $display("FAIL rr_no_done: got %0d want 0", n_done - d0);
        end
        send_cmd(4'd1, 4'd0);
        feed_byte(8'h55);
        wait_done(400, ok);
        n_cmp++;
        if (!ok || bus.err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL rr_recover: seen/err %b/%0d want 1/0",
                     ok, bus.err_code);
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_tx_len    = 4'd0;
        bus.cmd_rx_len    = 4'd0;
        bus.tx_byte       = 8'h00;
        bus.tx_byte_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_two_bytes();
        test_echo_mismatch();
        test_zero_len();
        test_timeout();
        test_response();
        test_resp_boundary();
        test_frame_error();
        test_reset_in_recv();
        n_cmp++;
        if (n_viol !== 0) begin
            n_bad++;
            $display("FAIL start_gate: got %0d want 0", n_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
